// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter that merges several AXI-stream byte sources into one uart_tx stream.
// Define UART_TX_ARB_HDR_EN to prefix every granted burst with a header byte carrying the source index.
module uart_tx_arbiter #(
    parameter int unsigned num_requesters = 4,
    parameter int unsigned max_beats      = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [num_requesters-1:0]           s_tvalid,
    output logic [num_requesters-1:0]           s_tready,
    input  logic [8*num_requesters-1:0]         s_tdata,
    input  logic [num_requesters-1:0]           s_tlast,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [7:0]                          m_tdata,
    output logic                                busy,
    output logic [$clog2(num_requesters)-1:0]   grant
);

    localparam int unsigned GW = $clog2(num_requesters);
    localparam int unsigned CW = (max_beats > 0) ? $clog2(max_beats + 1) : 1;
    localparam logic [CW-1:0] BEAT_LAST = (max_beats > 0) ? CW'(max_beats - 1) : '0;

`ifdef UART_TX_ARB_HDR_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PASS} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_PASS} state_t;
`endif

    state_t         r_state;
    logic [GW-1:0]  r_ptr;
    logic [GW-1:0]  r_grant;
    logic [CW-1:0]  r_beats;

    logic [GW-1:0]  w_idx;
    logic [GW-1:0]  w_pick;
    logic           w_any;
    logic           w_sel_valid;
    logic           w_sel_last;
    logic [7:0]     w_sel_data;
    logic           w_accept;
    logic           w_split;
    logic [GW-1:0]  w_ptr_next;

    // First requester found scanning r_ptr, r_ptr+1, ... modulo N.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int unsigned k = 0; k < num_requesters; k++) begin
            w_idx = GW'((32'(r_ptr) + k) % num_requesters);
            if (!w_any && s_tvalid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < num_requesters; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
                w_sel_data  = s_tdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        case (r_state)
            S_PASS: begin
                m_tvalid = w_sel_valid;
                m_tdata  = w_sel_data;
                for (int unsigned i = 0; i < num_requesters; i++) begin
                    if (r_grant == GW'(i)) s_tready[i] = m_tready;
                end
            end
`ifdef UART_TX_ARB_HDR_EN
            S_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = 8'(r_grant);
            end
`endif
            default: ;
        endcase
    end

    assign w_accept   = w_sel_valid && m_tready;
    assign w_split    = (max_beats > 0) && (r_beats == BEAT_LAST);
    assign w_ptr_next = (r_grant == GW'(num_requesters - 1)) ? '0 : r_grant + GW'(1);
    assign busy       = (r_state != S_IDLE);
    assign grant      = r_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_beats <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_beats <= '0;
`ifdef UART_TX_ARB_HDR_EN
                        r_state <= S_HDR;
`else
                        r_state <= S_PASS;
`endif
                    end
                end
`ifdef UART_TX_ARB_HDR_EN
                S_HDR: begin
                    if (m_tready) r_state <= S_PASS;
                end
`endif
                S_PASS: begin
                    if (w_accept) begin
                        // A split releases exactly like tlast; the source re-arbitrates for the remainder.
                        if (w_sel_last || w_split) begin
                            r_state <= S_IDLE;
                            r_ptr   <= w_ptr_next;
                        end else if (max_beats > 0) begin
                            r_beats <= r_beats + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
